aes128_decrypt_iter: RTL and testbench

- Iterative AES-128 decryption core; the receive-side counterpart of the combinational encryption round.
- Accepts one 128-bit ciphertext block with the final (round-10) round key and derives earlier round keys on the fly with the reverse key schedule.
- Executes one inverse round per clock and returns the plaintext over a valid/ready handshake.
- Sits between the link/storage receive path and the consumer of plaintext.

---
 rtl/aes_pkg.sv | 67 ++++++
 rtl/aes_inv_round.sv | 58 +++++
 rtl/aes128_decrypt_iter.sv | 93 +++++++++
 tb/tb_aes128_decrypt_iter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers: forward/inverse S-box, round constants,
// field multiply, and the state encoding of the iterative decryption core.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsmState_t;

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Rcon[1..10], Rcon[1] in the top byte.
  localparam logic [79:0] RCON_TABLE = 80'h01020408102040801b36;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] b);
    return INV_SBOX_TABLE[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] t;
    t = 8'h00;
    if (r >= 4'd1 && r <= 4'd10) t = RCON_TABLE[79 - 8*(int'(r) - 1) -: 8];
    return t;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and an
// optional InvMixColumns (skipped for the last round).
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] roundKey,
  input  logic         mcBypass,
  output logic [127:0] nextState
);

  // Byte (row r, column c) lives at index 4*c + r, byte 0 in the top bits.
  function automatic logic [127:0] invShiftRows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] invSubBytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127 - 8*i -: 8] = invSbox(s[127 - 8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] addRoundKey(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction

  function automatic logic [127:0] invMixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 32] = {
        gfMul(a0, 8'h0e) ^ gfMul(a1, 8'h0b) ^ gfMul(a2, 8'h0d) ^ gfMul(a3, 8'h09),
        gfMul(a0, 8'h09) ^ gfMul(a1, 8'h0e) ^ gfMul(a2, 8'h0b) ^ gfMul(a3, 8'h0d),
        gfMul(a0, 8'h0d) ^ gfMul(a1, 8'h09) ^ gfMul(a2, 8'h0e) ^ gfMul(a3, 8'h0b),
        gfMul(a0, 8'h0b) ^ gfMul(a1, 8'h0d) ^ gfMul(a2, 8'h09) ^ gfMul(a3, 8'h0e)
      };
    end
    return o;
  endfunction

  logic [127:0] keyedState;

  assign keyedState = addRoundKey(invSubBytes(invShiftRows(state)), roundKey);
  assign nextState  = mcBypass ? keyedState : invMixColumns(keyedState);

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryption: one inverse round per clock, round keys derived
// backwards from the round-10 key.
module aes128_decrypt_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output fsmState_t    dbgState
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid and
  // its data stay stable until that edge, and ready never depends on valid.

  // Step a round-r key back to round r-1; r selects Rcon[r].
  function automatic logic [127:0] invKeyStep(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] n0, n1, n2, n3, rot, sub;
    n3  = k[31:0] ^ k[63:32];
    n2  = k[63:32] ^ k[95:64];
    n1  = k[95:64] ^ k[127:96];
    rot = {n3[23:0], n3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    n0  = k[127:96] ^ sub ^ {rcon(r), 24'h0};
    return {n0, n1, n2, n3};
  endfunction

  fsmState_t    state;
  logic [127:0] stateReg;
  logic [127:0] rkReg;
  logic [3:0]   rnd;
  logic [127:0] roundOut;

  aes_inv_round uInvRound (
    .state    (stateReg),
    .roundKey (rkReg),
    .mcBypass (rnd == 4'd0),
    .nextState(roundOut)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stateReg  <= '0;
      rkReg     <= '0;
      rnd       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            stateReg <= ciphertext ^ key_last;
            rkReg    <= invKeyStep(key_last, 4'd10);
            rnd      <= 4'd9;
            in_ready <= 1'b0;
            state    <= RUN;
          end else begin
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          stateReg <= roundOut;
          if (rnd == 4'd0) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            rkReg <= invKeyStep(rkReg, rnd);
            rnd   <= rnd - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Intermediate round states never reach the output.
  assign plaintext = out_valid ? stateReg : '0;
  assign dbgState  = state;

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Directed bench for aes128_decrypt_iter using the FIPS-197 App. B and C.1 vectors.
module tb_aes128_decrypt_iter;
  import aes_pkg::*;

  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_C = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] ciphertext = '0;
  logic [127:0] key_last = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] plaintext;
  fsmState_t    dbgState;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  aes128_decrypt_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ciphertext(ciphertext),
    .key_last  (key_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .plaintext (plaintext),
    .dbgState  (dbgState)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one block for exactly one edge, then scramble the inputs.
  task automatic sendBlock(input logic [127:0] ct, input logic [127:0] key);
    in_valid   = 1'b1;
    ciphertext = ct;
    key_last   = key;
    tick();
    in_valid   = 1'b0;
    ciphertext = {$urandom(), $urandom(), $urandom(), $urandom()};
    key_last   = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic waitOut(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_low"}, 128'(out_valid), 128'(0));
    check({tag, "_ready_high"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    int   lat;
    int   nAcc;
    int   accCyc[2];
    logic prevReady;

    // Reset values
    repeat (3) tick();
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_plaintext", plaintext, 128'(0));
    check("rst_state", 128'(dbgState), 128'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", 128'(in_ready), 128'(1));

    // App. B with latency
    sendBlock(CT_B, KEY_B);
    check("b_accept_state", 128'(dbgState), 128'(RUN));
    check("b_busy_ready", 128'(in_ready), 128'(0));
    waitOut(lat);
    check("b_latency", 128'(lat), 128'(10));
    check("b_plaintext", plaintext, PT_B);
    handshake("b_hs");

    // App. C.1 with 20 cycles of backpressure
    sendBlock(CT_C, KEY_C);
    waitOut(lat);
    check("c_latency", 128'(lat), 128'(10));
    check("c_plaintext", plaintext, PT_C);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_plaintext", plaintext, PT_C);
      check("bp_in_ready", 128'(in_ready), 128'(0));
      check("bp_out_valid", 128'(out_valid), 128'(1));
    end
    handshake("bp_hs");

    // Busy gating: in_valid pulses during RUN and DONE are ignored
    sendBlock(CT_B, KEY_B);
    repeat (3) tick();
    in_valid   = 1'b1;
    ciphertext = CT_C;
    key_last   = KEY_C;
    repeat (2) tick();
    check("gate_run_state", 128'(dbgState), 128'(RUN));
    in_valid = 1'b0;
    waitOut(lat);
    check("gate_latency", 128'(lat), 128'(5));
    check("gate_first_pt", plaintext, PT_B);
    in_valid = 1'b1;
    repeat (3) tick();
    check("gate_done_state", 128'(dbgState), 128'(DONE));
    check("gate_done_pt", plaintext, PT_B);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("gate_idle_ready", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    check("gate_second_accept", 128'(dbgState), 128'(RUN));
    waitOut(lat);
    check("gate_second_lat", 128'(lat), 128'(10));
    check("gate_second_pt", plaintext, PT_C);
    handshake("gate_hs");

    // Async reset between edges at rnd = 5
    sendBlock(CT_B, KEY_B);
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 128'(in_ready), 128'(0));
    check("arst_out_valid", 128'(out_valid), 128'(0));
    check("arst_plaintext", plaintext, 128'(0));
    check("arst_state", 128'(dbgState), 128'(IDLE));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_ready_after", 128'(in_ready), 128'(1));
    sendBlock(CT_B, KEY_B);
    waitOut(lat);
    check("arst_b_latency", 128'(lat), 128'(10));
    check("arst_b_plaintext", plaintext, PT_B);
    handshake("arst_hs");

    // Back-to-back with in_valid and out_ready held high
    exp_q.push_back(PT_B);
    exp_q.push_back(PT_C);
    nAcc       = 0;
    accCyc[0]  = 0;
    accCyc[1]  = 0;
    in_valid   = 1'b1;
    ciphertext = CT_B;
    key_last   = KEY_B;
    out_ready  = 1'b1;
    for (int cyc = 1; cyc <= 60 && (nAcc < 2 || exp_q.size() > 0); cyc++) begin
      prevReady = in_ready;
      tick();
      if (prevReady && in_valid) begin
        accCyc[nAcc] = cyc;
        nAcc++;
        if (nAcc == 1) begin
          ciphertext = CT_C;
          key_last   = KEY_C;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        if (exp_q.size() > 0) check("b2b_plaintext", plaintext, exp_q.pop_front());
        else check("b2b_extra_output", 128'(out_valid), 128'(0));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_accepts", 128'(nAcc), 128'(2));
    check("b2b_pending", 128'(exp_q.size()), 128'(0));
    check("b2b_period", 128'(accCyc[1] - accCyc[0]), 128'(12));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
